// File: rtl/flag_unit.sv
// NZCV flag register and branch-resolution unit for the EX stage.
// Optional FLAG_BYPASS_EN: forward in-flight ALU flags to B.cond instead of stalling.
module flag_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_negative,
  input  logic       alu_zero,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       ex_valid,
  input  logic       set_flags,
  input  logic       stall,
  input  logic       flush,
  input  logic       br_valid,
  input  logic [1:0] br_type,
  input  logic [3:0] br_cond,
  input  logic       cbz_zero,
  output logic [3:0] flags_q,
  output logic       br_resolved,
  output logic       br_taken,
  output logic       flag_hazard
);

  typedef enum logic [1:0] {
    BR_COND   = 2'b00,
    BR_CBZ    = 2'b01,
    BR_UNCOND = 2'b10,
    BR_RSVD   = 2'b11
  } br_type_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'b0000, CC_NE = 4'b0001, CC_HS = 4'b0010, CC_LO = 4'b0011,
    CC_MI = 4'b0100, CC_PL = 4'b0101, CC_VS = 4'b0110, CC_VC = 4'b0111,
    CC_HI = 4'b1000, CC_LS = 4'b1001, CC_GE = 4'b1010, CC_LT = 4'b1011,
    CC_GT = 4'b1100, CC_LE = 4'b1101, CC_AL = 4'b1110, CC_NV = 4'b1111
  } cond_e;

  logic [3:0] alu_flags;
  logic [3:0] eff;
  logic       wr_pending;
  logic       upd;
  logic       cond_pass;
  logic       decision;
  logic       accept;
  logic       n, z, c, v;

  assign alu_flags  = {alu_negative, alu_zero, alu_carry, alu_overflow};
  // Flag writer in EX regardless of stall; stall only blocks the register write.
  assign wr_pending = ex_valid & set_flags & ~flush;
  assign upd        = wr_pending & ~stall;

`ifdef FLAG_BYPASS_EN
  assign eff         = wr_pending ? alu_flags : flags_q;
  assign flag_hazard = 1'b0;
`else
  assign eff         = flags_q;
  assign flag_hazard = br_valid & (br_type_e'(br_type) == BR_COND) & wr_pending;
`endif

  assign {n, z, c, v} = eff;

  always_comb begin
    cond_pass = 1'b0;
    case (cond_e'(br_cond))
      CC_EQ:   cond_pass = z;
      CC_NE:   cond_pass = ~z;
      CC_HS:   cond_pass = c;
      CC_LO:   cond_pass = ~c;
      CC_MI:   cond_pass = n;
      CC_PL:   cond_pass = ~n;
      CC_VS:   cond_pass = v;
      CC_VC:   cond_pass = ~v;
      CC_HI:   cond_pass = c & ~z;
      CC_LS:   cond_pass = ~c | z;
      CC_GE:   cond_pass = (n == v);
      CC_LT:   cond_pass = (n != v);
      CC_GT:   cond_pass = ~z & (n == v);
      CC_LE:   cond_pass = z | (n != v);
      CC_AL:   cond_pass = 1'b1;
      CC_NV:   cond_pass = 1'b1;
      default: cond_pass = 1'b1;
    endcase
  end

  always_comb begin
    decision = 1'b0;
    case (br_type_e'(br_type))
      BR_COND:   decision = cond_pass;
      BR_CBZ:    decision = cbz_zero;
      BR_UNCOND: decision = 1'b1;
      BR_RSVD:   decision = 1'b0;
      default:   decision = 1'b0;
    endcase
  end

  assign accept = br_valid & ~stall & ~flush & ~flag_hazard;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q     <= RESET_FLAGS;
      br_resolved <= 1'b0;
      br_taken    <= 1'b0;
    end else begin
      if (upd)
        flags_q <= alu_flags;
      br_resolved <= accept;
      br_taken    <= accept & decision;
    end
  end

endmodule

// File: tb/tb_flag_unit.sv
// Directed-vector bench for flag_unit; expectations adapt to FLAG_BYPASS_EN.
module tb_flag_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_negative, alu_zero, alu_carry, alu_overflow;
  logic       ex_valid, set_flags, stall, flush;
  logic       br_valid;
  logic [1:0] br_type;
  logic [3:0] br_cond;
  logic       cbz_zero;
  logic [3:0] flags_q;
  logic       br_resolved, br_taken, flag_hazard;

  int n_checks = 0;
  int n_fail   = 0;

  flag_unit #(.RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .reset(reset),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .ex_valid(ex_valid), .set_flags(set_flags), .stall(stall), .flush(flush),
    .br_valid(br_valid), .br_type(br_type), .br_cond(br_cond), .cbz_zero(cbz_zero),
    .flags_q(flags_q), .br_resolved(br_resolved), .br_taken(br_taken),
    .flag_hazard(flag_hazard)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ev, sf, st, fl, bv;
    logic [1:0] bt;
    logic [3:0] bc;
    logic       cz;
    logic [3:0] alu;
    logic [3:0] ef;
    logic       er, et, eh;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic sf, input logic st, input logic fl,
                       input logic bv, input logic [1:0] bt, input logic [3:0] bc,
                       input logic cz, input logic [3:0] alu);
    ex_valid = ev; set_flags = sf; stall = st; flush = fl;
    br_valid = bv; br_type = bt; br_cond = bc; cbz_zero = cz;
    {alu_negative, alu_zero, alu_carry, alu_overflow} = alu;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    drive(0, 0, 0, 0, 0, 2'b00, 4'h0, 0, 4'h0);
  endtask

  initial begin
    reset = 1'b1;
    // Reset with a branch and a flag write both asserted: reset must win.
    drive(1, 1, 0, 0, 1, 2'b10, 4'h0, 0, 4'b1111);
    #1;
    tick;
    tick;
    check("reset_flags", flags_q, 4'b0000);
    check("reset_res", {3'b0, br_resolved}, 4'd0);
    check("reset_tak", {3'b0, br_taken}, 4'd0);
    reset = 1'b0;
    idle;
    tick;
    check("post_reset_res", {3'b0, br_resolved}, 4'd0);

    //           ev sf st fl bv bt     bc     cz alu      ef       er et eh
    tbl.push_back('{0,0,0,0,1,2'b00,4'b0000,0,4'b0000,4'b0000,1,0,0}); // EQ on 0000
    tbl.push_back('{1,1,0,0,0,2'b00,4'b0000,0,4'b0110,4'b0110,0,0,0}); // SUBS Z,C
    tbl.push_back('{0,0,0,0,1,2'b00,4'b0000,0,4'b0000,4'b0110,1,1,0}); // EQ
    tbl.push_back('{0,0,0,0,1,2'b00,4'b0001,0,4'b0000,4'b0110,1,0,0}); // NE
    tbl.push_back('{0,0,0,0,1,2'b00,4'b1000,0,4'b0000,4'b0110,1,0,0}); // HI
    tbl.push_back('{0,0,0,0,1,2'b00,4'b1001,0,4'b0000,4'b0110,1,1,0}); // LS
    tbl.push_back('{0,0,0,0,1,2'b00,4'b0010,0,4'b0000,4'b0110,1,1,0}); // HS
    tbl.push_back('{0,0,0,0,1,2'b00,4'b0011,0,4'b0000,4'b0110,1,0,0}); // LO
    tbl.push_back('{1,1,0,0,0,2'b00,4'b0000,0,4'b1001,4'b1001,0,0,0}); // N,V
    tbl.push_back('{0,0,0,0,1,2'b00,4'b0100,0,4'b0000,4'b1001,1,1,0}); // MI
    tbl.push_back('{0,0,0,0,1,2'b00,4'b0101,0,4'b0000,4'b1001,1,0,0}); // PL
    tbl.push_back('{0,0,0,0,1,2'b00,4'b0110,0,4'b0000,4'b1001,1,1,0}); // VS
    tbl.push_back('{0,0,0,0,1,2'b00,4'b0111,0,4'b0000,4'b1001,1,0,0}); // VC
    tbl.push_back('{0,0,0,0,1,2'b00,4'b1010,0,4'b0000,4'b1001,1,1,0}); // GE
    tbl.push_back('{0,0,0,0,1,2'b00,4'b1011,0,4'b0000,4'b1001,1,0,0}); // LT
    tbl.push_back('{0,0,0,0,1,2'b00,4'b1100,0,4'b0000,4'b1001,1,1,0}); // GT
    tbl.push_back('{0,0,0,0,1,2'b00,4'b1101,0,4'b0000,4'b1001,1,0,0}); // LE
    tbl.push_back('{1,1,0,0,0,2'b00,4'b0000,0,4'b1000,4'b1000,0,0,0}); // N only
    tbl.push_back('{0,0,0,0,1,2'b00,4'b1010,0,4'b0000,4'b1000,1,0,0}); // GE
    tbl.push_back('{0,0,0,0,1,2'b00,4'b1011,0,4'b0000,4'b1000,1,1,0}); // LT
    tbl.push_back('{0,0,0,0,1,2'b00,4'b1100,0,4'b0000,4'b1000,1,0,0}); // GT
    tbl.push_back('{0,0,0,0,1,2'b00,4'b1101,0,4'b0000,4'b1000,1,1,0}); // LE
    tbl.push_back('{0,0,0,0,1,2'b00,4'b1110,0,4'b0000,4'b1000,1,1,0}); // AL
    tbl.push_back('{0,0,0,0,1,2'b00,4'b1111,0,4'b0000,4'b1000,1,1,0}); // NV
    tbl.push_back('{1,1,0,1,1,2'b10,4'b0000,0,4'b0100,4'b1000,0,0,0}); // flush
    tbl.push_back('{1,1,1,0,0,2'b00,4'b0000,0,4'b0001,4'b1000,0,0,0}); // stall no write
    tbl.push_back('{0,1,0,0,0,2'b00,4'b0000,0,4'b0001,4'b1000,0,0,0}); // !ex_valid
    tbl.push_back('{1,0,0,0,0,2'b00,4'b0000,0,4'b0001,4'b1000,0,0,0}); // !set_flags
    tbl.push_back('{0,0,0,0,1,2'b01,4'b0000,0,4'b0000,4'b1000,1,0,0}); // CBZ nz
    tbl.push_back('{0,0,0,0,1,2'b01,4'b0000,1,4'b0000,4'b1000,1,1,0}); // CBZ z
    tbl.push_back('{0,0,0,0,1,2'b10,4'b0001,0,4'b0000,4'b1000,1,1,0}); // B
    tbl.push_back('{0,0,0,0,1,2'b11,4'b1110,1,4'b0000,4'b1000,1,0,0}); // reserved
    tbl.push_back('{1,1,0,0,1,2'b01,4'b0000,1,4'b0100,4'b0100,1,1,0}); // SUBS + CBZ
    tbl.push_back('{0,0,0,0,1,2'b00,4'b0001,0,4'b0000,4'b0100,1,0,0}); // NE
    tbl.push_back('{0,0,0,0,1,2'b00,4'b1100,0,4'b0000,4'b0100,1,0,0}); // GT
    tbl.push_back('{0,0,0,0,1,2'b00,4'b1101,0,4'b0000,4'b0100,1,1,0}); // LE
    tbl.push_back('{0,0,1,0,1,2'b00,4'b0000,0,4'b0000,4'b0100,0,0,0}); // stalled EQ
    tbl.push_back('{1,1,0,0,1,2'b10,4'b0000,0,4'b0010,4'b0010,1,1,0}); // SUBS C + B
    tbl.push_back('{0,0,0,0,1,2'b00,4'b1000,0,4'b0000,4'b0010,1,1,0}); // HI
    tbl.push_back('{0,0,0,0,0,2'b00,4'b0000,0,4'b0000,4'b0010,0,0,0}); // idle

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ev, tbl[i].sf, tbl[i].st, tbl[i].fl, tbl[i].bv,
            tbl[i].bt, tbl[i].bc, tbl[i].cz, tbl[i].alu);
      #1;
      check($sformatf("v%0d_hazard", i), {3'b0, flag_hazard}, {3'b0, tbl[i].eh});
      tick;
      check($sformatf("v%0d_flags", i), flags_q, tbl[i].ef);
      check($sformatf("v%0d_res", i), {3'b0, br_resolved}, {3'b0, tbl[i].er});
      check($sformatf("v%0d_tak", i), {3'b0, br_taken}, {3'b0, tbl[i].et});
    end

    // CBZ held by a 3-cycle stall resolves once on release.
    drive(0, 0, 1, 0, 1, 2'b01, 4'h0, 1, 4'h0);
    for (int k = 0; k < 3; k++) begin
      tick;
      check($sformatf("stall%0d_res", k), {3'b0, br_resolved}, 4'd0);
    end
    stall = 1'b0;
    tick;
    check("stall_rel_res", {3'b0, br_resolved}, 4'd1);
    check("stall_rel_tak", {3'b0, br_taken}, 4'd1);
    idle;
    tick;
    check("stall_single_pulse", {3'b0, br_resolved}, 4'd0);

    // Clear flags, then same-cycle SUBS (N=1,V=0) with B.cond LT.
    drive(1, 1, 0, 0, 0, 2'b00, 4'h0, 0, 4'b0000);
    tick;
    check("clr_flags", flags_q, 4'b0000);
    drive(1, 1, 0, 0, 1, 2'b00, 4'b1011, 0, 4'b1000);
    #1;
`ifdef FLAG_BYPASS_EN
    check("byp_hazard", {3'b0, flag_hazard}, 4'd0);
    tick;
    check("byp_flags", flags_q, 4'b1000);
    check("byp_res", {3'b0, br_resolved}, 4'd1);
    check("byp_tak", {3'b0, br_taken}, 4'd1);
`else
    check("haz_hazard", {3'b0, flag_hazard}, 4'd1);
    tick;
    check("haz_flags", flags_q, 4'b1000);
    check("haz_res", {3'b0, br_resolved}, 4'd0);
    drive(0, 0, 0, 0, 1, 2'b00, 4'b1011, 0, 4'b0000);
    #1;
    check("haz_clear", {3'b0, flag_hazard}, 4'd0);
    tick;
    check("haz_late_res", {3'b0, br_resolved}, 4'd1);
    check("haz_late_tak", {3'b0, br_taken}, 4'd1);
`endif
    idle;
    tick;
    check("lt_pulse_end", {3'b0, br_resolved}, 4'd0);

    // Mid-operation reset with a pending branch and flag write.
    drive(1, 1, 0, 0, 1, 2'b10, 4'h0, 0, 4'b0111);
    reset = 1'b1;
    tick;
    check("midrst_flags", flags_q, 4'b0000);
    check("midrst_res", {3'b0, br_resolved}, 4'd0);
    check("midrst_tak", {3'b0, br_taken}, 4'd0);
    reset = 1'b0;
    idle;
    tick;
    check("midrst_after_res", {3'b0, br_resolved}, 4'd0);
    check("midrst_after_flags", flags_q, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
